// File: rtl/datapath_pkg.sv
// datapath_pkg: widths, ALU opcodes and NZCV flag bit positions shared by the datapath and controller
package datapath_pkg;
  localparam int DW = 8;
  localparam int NREG = 4;
  localparam int MDEPTH = 16;
  localparam int RW = $clog2(NREG);
  localparam int AW = $clog2(MDEPTH);
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_SHL   = 3'b101,
    ALU_SHR   = 3'b110,
    ALU_PASSB = 3'b111
  } alu_op_e;
endpackage

// File: rtl/datapath_unit_if.sv
// datapath_unit_if: controller->datapath bus (WE, ALUorM, ALUCntr, ALUSrc2, RDst3, RSrc1, Src2, MemWE) and datapath->controller (ALUFlags, Result, R3Out)
interface datapath_unit_if;
  import datapath_pkg::*;
  logic          WE;
  logic          ALUorM;
  logic [2:0]    ALUCntr;
  logic          ALUSrc2;
  logic [RW-1:0] RDst3;
  logic [RW-1:0] RSrc1;
  logic [DW-1:0] Src2;
  logic          MemWE;
  logic [3:0]    ALUFlags;
  logic [DW-1:0] Result;
  logic [DW-1:0] R3Out;
  modport master (output WE, ALUorM, ALUCntr, ALUSrc2, RDst3, RSrc1, Src2, MemWE, input ALUFlags, Result, R3Out);
  modport slave (input WE, ALUorM, ALUCntr, ALUSrc2, RDst3, RSrc1, Src2, MemWE, output ALUFlags, Result, R3Out);
endinterface

// File: rtl/datapath_unit_alu.sv
// alu_unit: combinational 8-bit ALU; in a, b, op -> out res, nzcv {N,Z,C,V}
module alu_unit
  import datapath_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  alu_op_e       op,
  output logic [DW-1:0] res,
  output logic [3:0]    nzcv
);
  logic [DW:0] sum;
  logic [DW:0] dif;
  logic c;
  logic v;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  always_comb begin
    res = b;
    c = 1'b0;
    v = 1'b0;
    case (op)
      ALU_ADD: begin
        res = sum[DW-1:0];
        c = sum[DW];
        v = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
      end
      ALU_SUB: begin
        res = dif[DW-1:0];
        c = ~dif[DW];
        v = (a[DW-1] != b[DW-1]) && (dif[DW-1] != a[DW-1]);
      end
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_XOR: res = a ^ b;
      ALU_SHL: begin
        res = {a[DW-2:0], 1'b0};
        c = a[DW-1];
      end
      ALU_SHR: begin
        res = {1'b0, a[DW-1:1]};
        c = a[0];
      end
      default: res = b;
    endcase
  end
  always_comb begin
    nzcv = '0;
    nzcv[FLAG_N] = res[DW-1];
    nzcv[FLAG_Z] = (res == '0);
    nzcv[FLAG_C] = c;
    nzcv[FLAG_V] = v;
  end
endmodule

// File: rtl/datapath_unit.sv
// datapath_unit: regfile + ALU + data memory + NZCV register; ports clk, reset (async active-low), bus (datapath_unit_if.slave)
module datapath_unit
  import datapath_pkg::*;
(
  input logic           clk,
  input logic           reset,
  datapath_unit_if.slave bus
);
  logic [DW-1:0] r [NREG];
  logic [DW-1:0] mem [MDEPTH];
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] alu_res;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] result;
  logic [3:0]    nzcv;
  logic [3:0]    flags;
  logic [DW-1:0] r3_out;
  assign a = r[bus.RSrc1];
  assign b = bus.ALUSrc2 ? bus.Src2 : r[bus.Src2[RW-1:0]];
  alu_unit u_alu (.a(a), .b(b), .op(alu_op_e'(bus.ALUCntr)), .res(alu_res), .nzcv(nzcv));
  assign mem_data = mem[alu_res[AW-1:0]];
  assign result = bus.ALUorM ? mem_data : alu_res;
  assign bus.Result = result;
  assign bus.ALUFlags = flags;
  assign bus.R3Out = r3_out;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r[i] <= '0;
      flags <= '0;
      r3_out <= '0;
    end else begin
      flags <= nzcv;
      if (bus.WE) r[bus.RDst3] <= result;
      if (bus.WE && bus.RDst3 == RW'(NREG - 1)) r3_out <= result;
    end
  end
  // memory is never cleared; the reset gate only suppresses a write while reset is held
  always_ff @(posedge clk) begin
    if (reset && bus.MemWE) mem[alu_res[AW-1:0]] <= r[bus.RDst3];
  end
endmodule

// File: tb/tb_datapath_unit.sv
// tb_datapath_unit: directed-vector self-checking bench for datapath_unit
module tb_datapath_unit;
  import datapath_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  datapath_unit_if bus ();
  datapath_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic set(input logic we, input logic aluorm, input alu_op_e op, input logic imm,
                     input logic [1:0] rdst, input logic [1:0] rsrc1, input logic [7:0] src2, input logic memwe);
    bus.WE = we;
    bus.ALUorM = aluorm;
    bus.ALUCntr = op;
    bus.ALUSrc2 = imm;
    bus.RDst3 = rdst;
    bus.RSrc1 = rsrc1;
    bus.Src2 = src2;
    bus.MemWE = memwe;
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic rd(input string tag, input logic [1:0] idx, input logic [7:0] exp);
    set(1'b0, 1'b0, ALU_PASSB, 1'b0, 2'd0, 2'd0, {6'd0, idx}, 1'b0);
    chk(tag, bus.Result, exp);
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    set(1'b0, 1'b0, ALU_ADD, 1'b1, 2'd0, 2'd0, 8'h00, 1'b0);
    tick();
    chk("rst_r3out", bus.R3Out, 8'h00);
    chk("rst_flags", {4'h0, bus.ALUFlags}, 8'h00);
    reset = 1'b1;
    set(1'b1, 1'b0, ALU_ADD, 1'b1, 2'd3, 2'd0, 8'h55, 1'b0);
    chk("add55_res", bus.Result, 8'h55);
    tick();
    chk("r3out_55", bus.R3Out, 8'h55);
    set(1'b1, 1'b0, ALU_ADD, 1'b1, 2'd3, 2'd0, 8'h33, 1'b0);
    #2 reset = 1'b0;
    tick();
    chk("midrst_r3out", bus.R3Out, 8'h00);
    chk("midrst_flags", {4'h0, bus.ALUFlags}, 8'h00);
    reset = 1'b1;
    rd("midrst_r3", 2'd3, 8'h00);
    chk("z_flags", {4'h0, bus.ALUFlags}, 8'h04);
    set(1'b1, 1'b0, ALU_ADD, 1'b1, 2'd1, 2'd0, 8'h7F, 1'b0);
    chk("add7f_res", bus.Result, 8'h7F);
    tick();
    set(1'b1, 1'b0, ALU_ADD, 1'b1, 2'd2, 2'd1, 8'h01, 1'b0);
    chk("add80_res", bus.Result, 8'h80);
    tick();
    chk("ovf_flags", {4'h0, bus.ALUFlags}, 8'h09);
    rd("r2_80", 2'd2, 8'h80);
    set(1'b1, 1'b0, ALU_ADD, 1'b1, 2'd1, 2'd0, 8'h05, 1'b0);
    tick();
    set(1'b0, 1'b0, ALU_SUB, 1'b1, 2'd0, 2'd1, 8'h05, 1'b0);
    chk("sub_zero_res", bus.Result, 8'h00);
    tick();
    chk("sub_zero_flags", {4'h0, bus.ALUFlags}, 8'h06);
    set(1'b0, 1'b0, ALU_SUB, 1'b1, 2'd0, 2'd1, 8'h06, 1'b0);
    chk("sub_borrow_res", bus.Result, 8'hFF);
    tick();
    chk("sub_borrow_flags", {4'h0, bus.ALUFlags}, 8'h08);
    set(1'b1, 1'b0, ALU_ADD, 1'b1, 2'd1, 2'd0, 8'h81, 1'b0);
    tick();
    set(1'b0, 1'b0, ALU_SHL, 1'b1, 2'd0, 2'd1, 8'h00, 1'b0);
    chk("shl_res", bus.Result, 8'h02);
    tick();
    chk("shl_flags", {4'h0, bus.ALUFlags}, 8'h02);
    set(1'b0, 1'b0, ALU_SHR, 1'b1, 2'd0, 2'd1, 8'h00, 1'b0);
    chk("shr_res", bus.Result, 8'h40);
    tick();
    chk("shr_flags", {4'h0, bus.ALUFlags}, 8'h02);
    set(1'b1, 1'b0, ALU_ADD, 1'b1, 2'd3, 2'd0, 8'hAA, 1'b0);
    tick();
    chk("r3out_aa", bus.R3Out, 8'hAA);
    set(1'b0, 1'b0, ALU_PASSB, 1'b1, 2'd3, 2'd0, 8'h1C, 1'b1);
    chk("passb_res", bus.Result, 8'h1C);
    tick();
    set(1'b1, 1'b1, ALU_PASSB, 1'b1, 2'd2, 2'd0, 8'h1C, 1'b0);
    chk("memrd_res", bus.Result, 8'hAA);
    tick();
    chk("memrd_flags_alu", {4'h0, bus.ALUFlags}, 8'h00);
    rd("r2_aa", 2'd2, 8'hAA);
    set(1'b1, 1'b1, ALU_PASSB, 1'b1, 2'd1, 2'd0, 8'h0C, 1'b1);
    chk("rbw_res", bus.Result, 8'hAA);
    tick();
    rd("rbw_r1", 2'd1, 8'hAA);
    set(1'b0, 1'b1, ALU_PASSB, 1'b1, 2'd0, 2'd0, 8'h0C, 1'b0);
    chk("rbw_mem", bus.Result, 8'h81);
    tick();
    set(1'b1, 1'b0, ALU_ADD, 1'b1, 2'd1, 2'd1, 8'h01, 1'b0);
    chk("nobypass_res", bus.Result, 8'hAB);
    #2;
    chk("nobypass_hold", bus.Result, 8'hAB);
    tick();
    rd("r1_ab", 2'd1, 8'hAB);
    set(1'b0, 1'b0, ALU_SUB, 1'b1, 2'd1, 2'd1, 8'hAB, 1'b0);
    chk("we0_res", bus.Result, 8'h00);
    tick();
    chk("we0_flags", {4'h0, bus.ALUFlags}, 8'h06);
    rd("we0_r1", 2'd1, 8'hAB);
    chk("r3out_final", bus.R3Out, 8'hAA);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/datapath_unit.md
Name: datapath_unit

Overview:
- Execution datapath directly downstream of the controller FSM. Consumes its per-instruction control and operand fields.
- Contains a 4x8 register file, an 8-bit ALU, a 16x8 data memory and a registered NZCV flag set.
- Flags feed back to the controller's ALUFlags input to drive branching.
- Executes one instruction per clock; write-back happens at the rising edge.

Parameters:
- DW, 8, datapath/register width
- NREG, 4, register count (index width 2)
- MDEPTH, 16, data memory words (address width 4)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- WE  in  1  register-file write enable
- ALUorM  in  1  write-back select: 0 = ALU result, 1 = memory read data
- ALUCntr  in  3  ALU operation
- ALUSrc2  in  1  operand B select: 1 = immediate Src2, 0 = register Src2[1:0]
- RDst3  in  2  destination register index
- RSrc1  in  2  operand A register index
- Src2  in  8  immediate, or register index in bits [1:0]
- MemWE  in  1  data memory write enable (tied 0 by current controller)
- ALUFlags  out  4  registered {N,Z,C,V}
- Result  out  8  combinational write-back value of the current instruction
- R3Out  out  8  registered contents of R3, for board LEDs

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. clk and reset as named above.
- While reset=0: R0..R3 = 0, ALUFlags = 4'b0000, R3Out = 0. Memory contents are NOT cleared.
- Reset assertion mid-instruction aborts the pending write. The first edge after release executes normally.
- Operands (combinational):
  - A = R[RSrc1]
  - B = ALUSrc2 ? Src2 : R[Src2[1:0]]
- ALUCntr encoding:
  - 000 ADD (A+B)
  - 001 SUB (A-B)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL (A<<1)
  - 110 SHR logical (A>>1)
  - 111 PASSB (B)
- ALU result is the low 8 bits. Arithmetic is 9-bit internally for carry.
- Flags, computed on the ALU result (never on memory data):
  - N = res[7]
  - Z = (res==0)
  - C: ADD carry-out; SUB = NOT borrow (1 when A>=B unsigned); SHL = A[7]; SHR = A[0]; else 0
  - V: ADD/SUB signed overflow; else 0
- Flags register on every rising edge regardless of WE, so ALUFlags reflects the previous cycle's instruction. Latency 1.
- Memory read: asynchronous, MemData = Mem[ALUres[3:0]]. ALUres[7:4] is ignored (address wraps modulo 16).
- Memory write: at the edge when MemWE=1, Mem[ALUres[3:0]] <= R[RDst3].
- Result = ALUorM ? MemData : ALUres.
- Register write: at the edge when WE=1, R[RDst3] <= Result.
  - R0 is not hardwired; it is writable.
  - Reads in the same cycle return the old value. The new value is visible the following cycle; no bypass.
- Simultaneous MemWE and WE with ALUorM=1 at the same address:
  - Register receives the old memory word (read-before-write).
  - Memory receives the old R[RDst3].
- R3Out is registered. It updates at the same edge as any R3 write, so it always equals R[3].
- All control inputs are sampled only at the rising edge. No internal FSM; no stalls.

Decomposition:
- Shared package datapath_pkg:
  - DW, NREG, MDEPTH constants
  - alu_op_e enum matching the ALUCntr encoding (the controller imports it)
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- One sub-module, alu_unit: purely combinational. Inputs A, B, op; outputs res[7:0] and nzcv[3:0].
- Register file, memory and flag register stay in datapath_unit.

Test Plan:
- Reset: pulse reset low mid-write with WE=1 -> R0..R3=0, ALUFlags=0000, R3Out=0; no write occurs.
- Immediate ADD/SUB:
  - WE=1, ALUSrc2=1, RSrc1=0, RDst3=1, Src2=8'h7F, ADD -> R1=7F.
  - Then RSrc1=1, Src2=1, ADD into R2 -> R2=80; next cycle ALUFlags=1001 (N,V).
- SUB borrow and zero:
  - R1=05, SUB immediate 05 -> Result=00, ALUFlags=0110 next cycle.
  - SUB 06 -> FF, ALUFlags=1000.
- Shifts and carry: R1=81; SHL -> 02, C=1; SHR -> 40, C=1.
- Memory round trip:
  - R3=AA, RSrc1=0, immediate 8'h1C, PASSB, MemWE=1, RDst3=3 -> Mem[C]=AA (address wraps).
  - Then ALUorM=1, WE=1, RDst3=2 at same address -> R2=AA.
- No bypass / WE=0:
  - Write R1=10 and read R1 in the same cycle -> operand sees old value.
  - WE=0 -> no register change, yet flags still update.
